divisor_serial: RTL and testbench

DIVISOR_SERIAL -- requirements
Module: divisor_serial

---
 rtl/div_pkg.sv | 11 +
 rtl/control_div.sv | 55 +++++
 rtl/divisor_serial.sv | 90 +++++++++
 tb/tb_divisor_serial.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared parameters and state encoding for the serial restoring divider.
package div_pkg;
  localparam int DIV_N  = 16;
  localparam int DIV_KW = $clog2(DIV_N);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/control_div.sv
// Divider sequencer: IDLE/DIV/DONE FSM plus the iteration counter K.
module control_div
  import div_pkg::*;
#(
  parameter int KW = DIV_KW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_st,
  input  logic          i_k_last,
  input  logic          i_ovf,
  output logic [KW-1:0] o_k,
  output logic          o_idle,
  output logic          o_div,
  output logic          o_done,
  output logic          o_load,
  output logic          o_ovf_load,
  output logic          o_finish
);
  state_t        r_state, w_next;
  logic [KW-1:0] r_k;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (i_st) w_next = i_ovf ? ST_DONE : ST_DIV;
      ST_DIV:  if (i_k_last) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_idle     = (r_state == ST_IDLE);
    o_div      = (r_state == ST_DIV);
    o_done     = (r_state == ST_DONE);
    o_load     = o_idle & i_st & ~i_ovf;
    o_ovf_load = o_idle & i_st & i_ovf;
    o_finish   = o_div & i_k_last;
  end

  // K restarts on every accepted start so an aborted run never leaks a count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    r_k <= '0;
    else if (o_idle && i_st)     r_k <= '0;
    else if (o_div)              r_k <= r_k + 1'b1;
  end

  assign o_k = r_k;
endmodule

// File: rtl/divisor_serial.sv
// Serial restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per cycle.
module divisor_serial
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           St,
  input  logic [2*N-1:0] Dividendo,
  input  logic [N-1:0]   Divisor,
  output logic [N-1:0]   Quociente,
  output logic [N-1:0]   Resto,
  output logic           Idle,
  output logic           Done,
  output logic           Ovf
);
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  logic [2*N:0]  r_acc;
  logic [N-1:0]  r_dvs;
  logic [N-1:0]  r_quo, r_rem;
  logic          r_ovf;

  logic [KW-1:0] w_k;
  logic          w_k_last, w_ovf, w_div;
  logic          w_load, w_ovf_load, w_finish;
  logic [2*N:0]  w_shift, w_next;
  logic [N:0]    w_hi, w_diff;
  logic          w_ge;

  // Quotient would not fit in N bits (also catches divide-by-zero)
  assign w_ovf    = (Dividendo[2*N-1:N] >= Divisor);
  assign w_k_last = (w_k == KW'(N - 1));

  control_div #(.KW(KW)) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .i_st       (St),
    .i_k_last   (w_k_last),
    .i_ovf      (w_ovf),
    .o_k        (w_k),
    .o_idle     (Idle),
    .o_div      (w_div),
    .o_done     (Done),
    .o_load     (w_load),
    .o_ovf_load (w_ovf_load),
    .o_finish   (w_finish)
  );

  assign w_shift = r_acc << 1;
  assign w_hi    = w_shift[2*N:N];
  assign w_ge    = (w_hi >= {1'b0, r_dvs});
  assign w_diff  = w_hi - {1'b0, r_dvs};
  assign w_next  = {(w_ge ? w_diff : w_hi), w_shift[N-1:1], w_ge};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
      r_dvs <= '0;
    end else if (w_load) begin
      r_acc <= {1'b0, Dividendo};
      r_dvs <= Divisor;
    end else if (w_div) begin
      r_acc <= w_next;
    end
  end

  // Results hold from DONE until the next accepted start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_quo <= '0;
      r_rem <= '0;
      r_ovf <= 1'b0;
    end else if (w_ovf_load) begin
      r_quo <= '0;
      r_rem <= '0;
      r_ovf <= 1'b1;
    end else if (w_load) begin
      r_ovf <= 1'b0;
    end else if (w_finish) begin
      r_quo <= w_next[N-1:0];
      r_rem <= w_next[2*N-1:N];
    end
  end

  assign Quociente = r_quo;
  assign Resto     = r_rem;
  assign Ovf       = r_ovf;
endmodule

// File: tb/tb_divisor_serial.sv
// Directed and random checks for divisor_serial (N=16).
module tb_divisor_serial;
  localparam int N = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           St = 1'b0;
  logic [2*N-1:0] Dividendo = '0;
  logic [N-1:0]   Divisor = '0;
  logic [N-1:0]   Quociente, Resto;
  logic           Idle, Done, Ovf;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  divisor_serial #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .St        (St),
    .Dividendo (Dividendo),
    .Divisor   (Divisor),
    .Quociente (Quociente),
    .Resto     (Resto),
    .Idle      (Idle),
    .Done      (Done),
    .Ovf       (Ovf)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Start one division at a negedge and wait (bounded) for Done; optionally
  // re-pulse St with other operands mid-DIV to prove it is ignored.
  task automatic run(input string tag, input logic [31:0] dd, input logic [15:0] dv,
                     input bit disturb, input logic [15:0] eq, input logic [15:0] er,
                     input bit eo, input bit chk_lat);
    int  n;
    bit  seen;
    n = 0;
    seen = 0;
    @(negedge clk);
    St = 1'b1; Dividendo = dd; Divisor = dv;
    @(negedge clk);
    St = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (Done) begin seen = 1; break; end
      if (disturb && n == 3) begin St = 1'b1; Dividendo = 32'h0000_0001; Divisor = 16'h0003; end
      if (disturb && n == 4) St = 1'b0;
      @(posedge clk); n++;
      @(negedge clk);
    end
    chk({tag, "_seen_done"}, seen, 1'b1);
    if (chk_lat) begin
      chk({tag, "_latency"}, n, eo ? 0 : N);
      chk({tag, "_idle_at_done"}, Idle, 1'b0);
    end
    chk({tag, "_quo"}, Quociente, eq);
    chk({tag, "_rem"}, Resto, er);
    chk({tag, "_ovf"}, Ovf, eo);
    @(negedge clk);
    if (chk_lat) begin
      chk({tag, "_done_1cyc"}, Done, 1'b0);
      chk({tag, "_idle_after"}, Idle, 1'b1);
    end
  endtask

  initial begin
    int          gap, dones;
    bit          seen;
    logic [31:0] dd;
    logic [15:0] dv;

    repeat (2) @(negedge clk);
    chk("rst_idle", Idle, 1'b1);
    chk("rst_done", Done, 1'b0);
    chk("rst_quo", Quociente, 16'h0);
    chk("rst_rem", Resto, 16'h0);
    chk("rst_ovf", Ovf, 1'b0);
    rst = 1'b1;
    @(negedge clk);

    run("d100_7",   32'd100,       16'd7,      0, 16'd14,     16'd2,      0, 1);
    repeat (3) @(negedge clk);
    chk("hold_quo", Quociente, 16'd14);
    chk("hold_rem", Resto, 16'd2);
    run("max",      32'hFFFE_FFFF, 16'hFFFF,   0, 16'hFFFF,   16'hFFFE,   0, 1);
    run("ovf_eq",   32'h0005_0000, 16'd5,      0, 16'h0,      16'h0,      1, 1);
    run("div0",     32'h0000_1234, 16'd0,      0, 16'h0,      16'h0,      1, 1);
    run("zero_dd",  32'd0,         16'd1,      0, 16'h0,      16'h0,      0, 1);
    run("by_one",   32'h0000_FFFF, 16'd1,      0, 16'hFFFF,   16'h0,      0, 1);
    run("small",    32'd7,         16'd100,    0, 16'h0,      16'd7,      0, 1);
    run("hi_below", 32'h0004_FFFF, 16'd5,      0, 16'hFFFF,   16'd4,      0, 1);
    run("ignore_st",32'd100,       16'd7,      1, 16'd14,     16'd2,      0, 1);

    // St held high: back-to-back operations, one IDLE cycle between DONEs
    @(negedge clk);
    St = 1'b1; Dividendo = 32'd100; Divisor = 16'd7;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin @(negedge clk); seen = Done; end
    chk("hold_st_first", seen, 1'b1);
    gap = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin @(negedge clk); gap++; seen = Done; end
    chk("hold_st_second", seen, 1'b1);
    chk("hold_st_gap", gap, N + 2);
    chk("hold_st_quo", Quociente, 16'd14);
    St = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the 8th DIV cycle aborts with no Done
    St = 1'b1; Dividendo = 32'd1000; Divisor = 16'd10;
    @(negedge clk);
    St = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid_in_div", Idle, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_idle", Idle, 1'b1);
    chk("mid_rst_done", Done, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    dones = 0;
    for (int i = 0; i < 24; i++) begin @(negedge clk); if (Done) dones++; end
    chk("mid_rst_no_done", dones, 0);
    run("post_rst", 32'd1000,      16'd10,     0, 16'd100,    16'd0,      0, 1);

    // Random non-overflow operands, checked against exact division
    for (int i = 0; i < 1000; i++) begin
      dv = 16'($urandom_range(1, 65535));
      dd = $urandom();
      if (dd[31:16] >= dv) dd[31:16] = dd[31:16] % dv;
      run("rnd", dd, dv, 0, 16'(dd / {16'h0, dv}), 16'(dd % {16'h0, dv}), 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
